sw_alloc_lock: RTL and testbench

- Switch allocator that sequences the router crossbar.
- Each cycle it decides which input port drives each output port, holds that connection from header flit to tail flit (wormhole lock), and shares each output among inputs by round-robin.
- It drives the crossbar's per-input one-hot port_sel_array and pops the winning input buffers.
- It sits between the input-port buffers/route compute and the crossbar.

---
 rtl/sw_alloc_lock.sv | 206 ++++++++++++++++++++
 tb/tb_sw_alloc_lock.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_alloc_lock.sv
// ---------------------------------------------------------------------------
// sw_alloc_lock
//
// Switch allocator for a wormhole router crossbar. Every output port is
// shared among the input ports by a round-robin arbiter; once a multi-flit
// packet's header wins an output, that output is locked to the winning input
// until the tail flit has crossed. Decisions are registered, so the crossbar
// select, grants and output-valid flags for cycle t inputs appear in cycle
// t+1.
//
// Ports:
//   clk            clock
//   reset          asynchronous, active-high reset
//   req            input i holds a flit ready to send
//   hdr            flit at input i is a header
//   tail           flit at input i is a tail (hdr=tail=1 is a single flit)
//   dest_array     binary destination output per input, slice i at
//                  [(i+1)*W-1 : i*W]
//   out_ready      output o can accept a flit this cycle
//   port_sel_array per-input one-hot crossbar select (no U-turn, so
//                  PORT_NUM-1 bits per input), zero when idle
//   grant          input i's flit traverses the crossbar; pop input i
//   out_valid      output o carries a valid flit
//   dest_err       input i requested its own port or a nonexistent port
// ---------------------------------------------------------------------------
module sw_alloc_lock #(
    parameter int PORT_NUM           = 5,
    parameter int PORT_SEL_WIDTH     = PORT_NUM - 1,
    parameter int PORT_NUM_BCD_WIDTH = $clog2(PORT_NUM)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [PORT_NUM-1:0]                    req,
    input  logic [PORT_NUM-1:0]                    hdr,
    input  logic [PORT_NUM-1:0]                    tail,
    input  logic [PORT_NUM*PORT_NUM_BCD_WIDTH-1:0] dest_array,
    input  logic [PORT_NUM-1:0]                    out_ready,
    output logic [PORT_NUM*PORT_SEL_WIDTH-1:0]     port_sel_array,
    output logic [PORT_NUM-1:0]                    grant,
    output logic [PORT_NUM-1:0]                    out_valid,
    output logic [PORT_NUM-1:0]                    dest_err
);

    localparam int W = PORT_NUM_BCD_WIDTH;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } outState_t;

    outState_t                     state_q [PORT_NUM];
    outState_t                     state_d [PORT_NUM];
    logic [W-1:0]                  owner_q [PORT_NUM];
    logic [W-1:0]                  owner_d [PORT_NUM];
    logic [W-1:0]                  rr_q    [PORT_NUM];
    logic [W-1:0]                  rr_d    [PORT_NUM];
    logic [PORT_NUM-1:0]           busy_q;
    logic [PORT_NUM-1:0]           busy_d;

    logic [PORT_NUM-1:0]           grant_q;
    logic [PORT_NUM-1:0]           grant_d;
    logic [PORT_NUM-1:0]           outValid_q;
    logic [PORT_NUM-1:0]           outValid_d;
    logic [PORT_NUM-1:0]           destErr_q;
    logic [PORT_NUM-1:0]           destErr_d;
    logic [PORT_NUM*PORT_SEL_WIDTH-1:0] portSel_q;
    logic [PORT_NUM*PORT_SEL_WIDTH-1:0] portSel_d;

    logic [W-1:0]                  dest     [PORT_NUM];
    logic [PORT_NUM-1:0]           validReq [PORT_NUM];
    logic [W:0]                    pick     [PORT_NUM];
    logic [PORT_NUM-1:0]           winValid;
    logic [W-1:0]                  winIdx   [PORT_NUM];

    // Round-robin search: first set bit of cand at or after rr, wrapping.
    // Scanning from the far end lets the nearest candidate overwrite the
    // result last. MSB of the result flags that a candidate was found.
    function automatic logic [W:0] pickRr(input logic [PORT_NUM-1:0] cand,
                                          input logic [W-1:0] rr);
        logic [W:0] res;
        int         idx;
        res = '0;
        for (int k = PORT_NUM - 1; k >= 0; k--) begin
            idx = int'(rr) + k;
            if (idx >= PORT_NUM) idx = idx - PORT_NUM;
            if (cand[idx]) res = {1'b1, W'(idx)};
        end
        return res;
    endfunction

    // Index of the port following x, modulo PORT_NUM.
    function automatic logic [W-1:0] nextIdx(input logic [W-1:0] x);
        if (int'(x) == PORT_NUM - 1) return '0;
        return W'(int'(x) + 1);
    endfunction

    // Unpack destinations and build the request matrix validReq[o][i].
    // A request is only valid toward an existing port other than the
    // requester itself; anything else is flagged as a destination error.
    always_comb begin
        destErr_d = '0;
        for (int o = 0; o < PORT_NUM; o++) validReq[o] = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            dest[i] = dest_array[i*W +: W];
            if (req[i] && (int'(dest[i]) == i || int'(dest[i]) >= PORT_NUM))
                destErr_d[i] = 1'b1;
            for (int o = 0; o < PORT_NUM; o++) begin
                if (req[i] && int'(dest[i]) == o && o != i)
                    validReq[o][i] = 1'b1;
            end
        end
    end

    // Per-output arbitration and next state. An idle output arbitrates only
    // among headers from inputs that do not already hold an output; a locked
    // output serves only body/tail flits of its owner, so a stray header at
    // the owner is ignored. Releasing on a tail leaves the output idle for
    // the next cycle, which is when the next header can win.
    always_comb begin
        winValid = '0;
        busy_d   = busy_q;
        for (int o = 0; o < PORT_NUM; o++) begin
            winIdx[o]  = '0;
            pick[o]    = '0;
            state_d[o] = state_q[o];
            owner_d[o] = owner_q[o];
            rr_d[o]    = rr_q[o];
            if (state_q[o] == IDLE) begin
                pick[o] = pickRr(validReq[o] & hdr & ~busy_q, rr_q[o]);
                if (out_ready[o] && pick[o][W]) begin
                    winValid[o] = 1'b1;
                    winIdx[o]   = pick[o][W-1:0];
                    if (tail[pick[o][W-1:0]]) begin
                        rr_d[o] = nextIdx(pick[o][W-1:0]);
                    end else begin
                        state_d[o]                = LOCKED;
                        owner_d[o]                = pick[o][W-1:0];
                        busy_d[pick[o][W-1:0]]    = 1'b1;
                    end
                end
            end else begin
                if (validReq[o][owner_q[o]] && !hdr[owner_q[o]] && out_ready[o]) begin
                    winValid[o] = 1'b1;
                    winIdx[o]   = owner_q[o];
                    if (tail[owner_q[o]]) begin
                        state_d[o]            = IDLE;
                        busy_d[owner_q[o]]    = 1'b0;
                        rr_d[o]               = nextIdx(owner_q[o]);
                    end
                end
            end
        end
    end

    // Translate per-output winners into per-input grants and crossbar
    // selects. Since an input never selects itself, outputs above the input
    // index shift down by one bit in that input's select slice.
    always_comb begin
        grant_d    = '0;
        outValid_d = '0;
        portSel_d  = '0;
        for (int j = 0; j < PORT_NUM; j++) begin
            for (int o = 0; o < PORT_NUM; o++) begin
                if (o != j && winValid[o] && int'(winIdx[o]) == j) begin
                    grant_d[j]    = 1'b1;
                    outValid_d[o] = 1'b1;
                    portSel_d[j*PORT_SEL_WIDTH + ((o > j) ? o - 1 : o)] = 1'b1;
                end
            end
        end
    end

    // State and output registers. Reset abandons any packet in flight:
    // every output returns to idle with its pointer at port 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int o = 0; o < PORT_NUM; o++) begin
                state_q[o] <= IDLE;
                owner_q[o] <= '0;
                rr_q[o]    <= '0;
            end
            busy_q     <= '0;
            grant_q    <= '0;
            outValid_q <= '0;
            destErr_q  <= '0;
            portSel_q  <= '0;
        end else begin
            for (int o = 0; o < PORT_NUM; o++) begin
                state_q[o] <= state_d[o];
                owner_q[o] <= owner_d[o];
                rr_q[o]    <= rr_d[o];
            end
            busy_q     <= busy_d;
            grant_q    <= grant_d;
            outValid_q <= outValid_d;
            destErr_q  <= destErr_d;
            portSel_q  <= portSel_d;
        end
    end

    assign grant          = grant_q;
    assign out_valid      = outValid_q;
    assign dest_err       = destErr_q;
    assign port_sel_array = portSel_q;

endmodule

// File: tb/tb_sw_alloc_lock.sv
// ---------------------------------------------------------------------------
// tb_sw_alloc_lock
//
// Self-checking bench for sw_alloc_lock. Inputs are driven on the falling
// edge, the reference model is stepped with the same inputs, and the DUT's
// registered outputs are compared on the following falling edge. Directed
// scenarios are followed by packet-level random traffic and by fully random
// input noise.
// ---------------------------------------------------------------------------
module tb_sw_alloc_lock;

    localparam int N  = 5;
    localparam int W  = 3;
    localparam int PS = N - 1;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N-1:0]   hdr;
    logic [N-1:0]   tail;
    logic [N*W-1:0] destArray;
    logic [N-1:0]   outReady;
    logic [N*PS-1:0] portSel;
    logic [N-1:0]   grant;
    logic [N-1:0]   outValid;
    logic [N-1:0]   destErr;

    int checks   = 0;
    int failures = 0;

    // Reference model: owner of each output (-1 when free) and its pointer.
    int ownerM [N];
    int rrM    [N];
    logic [N-1:0]    expGrant;
    logic [N-1:0]    expValid;
    logic [N-1:0]    expErr;
    logic [N*PS-1:0] expSel;

    // Random packet sources, one per input.
    int pktLeft  [N];
    int pktDest  [N];
    bit pktFirst [N];
    bit pktBad   [N];
    logic [N-1:0]   gr, gh, gt, grdy;
    logic [N*W-1:0] gd;

    sw_alloc_lock #(.PORT_NUM(N)) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .hdr            (hdr),
        .tail           (tail),
        .dest_array     (destArray),
        .out_ready      (outReady),
        .port_sel_array (portSel),
        .grant          (grant),
        .out_valid      (outValid),
        .dest_err       (destErr)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Counts one comparison and reports it if the values differ.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic int destOf(input logic [N*W-1:0] d, input int i);
        return int'(d[i*W +: W]);
    endfunction

    function automatic logic [N*W-1:0] dsts(input int d0, input int d1,
                                            input int d2, input int d3,
                                            input int d4);
        logic [N*W-1:0] v;
        v = '0;
        v[0*W +: W] = W'(d0);
        v[1*W +: W] = W'(d1);
        v[2*W +: W] = W'(d2);
        v[3*W +: W] = W'(d3);
        v[4*W +: W] = W'(d4);
        return v;
    endfunction

    task automatic modelReset();
        for (int o = 0; o < N; o++) begin
            ownerM[o] = -1;
            rrM[o]    = 0;
        end
    endtask

    // Marks input w as sending to output o in the expected outputs.
    task automatic serve(input int w, input int o);
        expGrant[w] = 1'b1;
        expValid[o] = 1'b1;
        expSel[w*PS + ((o > w) ? o - 1 : o)] = 1'b1;
    endtask

    // One cycle of the allocation rules applied to the current inputs.
    task automatic modelStep();
        bit busyM [N];
        int w;
        int d;
        expGrant = '0;
        expValid = '0;
        expErr   = '0;
        expSel   = '0;
        for (int i = 0; i < N; i++) busyM[i] = 1'b0;
        for (int o = 0; o < N; o++) if (ownerM[o] >= 0) busyM[ownerM[o]] = 1'b1;
        for (int i = 0; i < N; i++) begin
            d = destOf(destArray, i);
            if (req[i] && (d == i || d >= N)) expErr[i] = 1'b1;
        end
        for (int o = 0; o < N; o++) begin
            if (ownerM[o] >= 0) begin
                w = ownerM[o];
                if (req[w] && !hdr[w] && destOf(destArray, w) == o && outReady[o]) begin
                    serve(w, o);
                    if (tail[w]) begin
                        ownerM[o] = -1;
                        rrM[o]    = (w + 1) % N;
                    end
                end
            end else if (outReady[o]) begin
                for (int k = 0; k < N; k++) begin
                    w = (rrM[o] + k) % N;
                    if (req[w] && hdr[w] && !busyM[w] && w != o &&
                        destOf(destArray, w) == o) begin
                        serve(w, o);
                        if (tail[w]) rrM[o] = (w + 1) % N;
                        else         ownerM[o] = w;
                        break;
                    end
                end
            end
        end
    endtask

    // Drives one cycle of inputs (called on a falling edge), steps the model
    // and compares every registered output one edge later.
    task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] h,
                                 input logic [N-1:0] t, input logic [N*W-1:0] d,
                                 input logic [N-1:0] rdy);
        req       = r;
        hdr       = h;
        tail      = t;
        destArray = d;
        outReady  = rdy;
        modelStep();
        @(posedge clk);
        @(negedge clk);
        checkOutput("grant", 32'(grant), 32'(expGrant));
        checkOutput("out_valid", 32'(outValid), 32'(expValid));
        checkOutput("port_sel", 32'(portSel), 32'(expSel));
        checkOutput("dest_err", 32'(destErr), 32'(expErr));
    endtask

    // Directed scenarios, then random packet traffic and raw input noise.
    initial begin
        req       = '0;
        hdr       = '0;
        tail      = '0;
        destArray = '0;
        outReady  = '1;
        reset     = 1'b1;
        modelReset();
        for (int i = 0; i < N; i++) begin
            pktLeft[i]  = 0;
            pktDest[i]  = 0;
            pktFirst[i] = 1'b0;
            pktBad[i]   = 1'b0;
        end
        repeat (2) @(negedge clk);
        checkOutput("rst_grant", 32'(grant), 32'h0);
        checkOutput("rst_out_valid", 32'(outValid), 32'h0);
        checkOutput("rst_port_sel", 32'(portSel), 32'h0);
        checkOutput("rst_dest_err", 32'(destErr), 32'h0);
        reset = 1'b0;

        $display("[TB] single-flit packet input 0 -> output 2");
        applyStimulus(5'b00001, 5'b00001, 5'b00001, dsts(2, 0, 0, 0, 0), 5'b11111);
        checkOutput("t1_grant", 32'(grant), 32'h01);
        checkOutput("t1_out_valid", 32'(outValid), 32'h04);
        checkOutput("t1_port_sel", 32'(portSel), 32'h00002);

        $display("[TB] round robin inputs 1,3,4 -> output 0");
        for (int c = 0; c < 3; c++) begin
            applyStimulus(5'b11010, 5'b11010, 5'b11010, dsts(0, 0, 0, 0, 0), 5'b11111);
            case (c)
                0: begin
                    checkOutput("t2_grant0", 32'(grant), 32'h02);
                    checkOutput("t2_sel0", 32'(portSel), 32'h00010);
                end
                1: begin
                    checkOutput("t2_grant1", 32'(grant), 32'h08);
                    checkOutput("t2_sel1", 32'(portSel), 32'h01000);
                end
                default: begin
                    checkOutput("t2_grant2", 32'(grant), 32'h10);
                    checkOutput("t2_sel2", 32'(portSel), 32'h10000);
                end
            endcase
            checkOutput("t2_out_valid", 32'(outValid), 32'h01);
        end

        $display("[TB] wormhole lock input 2 -> output 4 against input 1");
        applyStimulus(5'b00100, 5'b00100, 5'b00000, dsts(0, 4, 4, 0, 0), 5'b11111);
        checkOutput("t3_hdr_grant", 32'(grant), 32'h04);
        checkOutput("t3_hdr_sel", 32'(portSel), 32'h00800);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(5'b00110, 5'b00010, (c == 2) ? 5'b00110 : 5'b00010,
                          dsts(0, 4, 4, 0, 0), 5'b11111);
            checkOutput("t3_body_grant", 32'(grant), 32'h04);
            checkOutput("t3_body_valid", 32'(outValid), 32'h10);
        end
        applyStimulus(5'b00010, 5'b00010, 5'b00010, dsts(0, 4, 4, 0, 0), 5'b11111);
        checkOutput("t3_next_grant", 32'(grant), 32'h02);
        checkOutput("t3_next_sel", 32'(portSel), 32'h00080);

        $display("[TB] backpressure on locked output 3");
        applyStimulus(5'b00001, 5'b00001, 5'b00000, dsts(3, 0, 0, 0, 3), 5'b11111);
        checkOutput("t4_hdr_grant", 32'(grant), 32'h01);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(5'b00001, 5'b00000, 5'b00000, dsts(3, 0, 0, 0, 3), 5'b10111);
            checkOutput("t4_stall_grant", 32'(grant), 32'h00);
            checkOutput("t4_stall_valid", 32'(outValid), 32'h00);
        end
        applyStimulus(5'b10001, 5'b10000, 5'b10000, dsts(3, 0, 0, 0, 3), 5'b11111);
        checkOutput("t4_resume_grant", 32'(grant), 32'h01);
        applyStimulus(5'b10001, 5'b10000, 5'b10001, dsts(3, 0, 0, 0, 3), 5'b11111);
        checkOutput("t4_tail_grant", 32'(grant), 32'h01);
        applyStimulus(5'b10000, 5'b10000, 5'b10000, dsts(3, 0, 0, 0, 3), 5'b11111);
        checkOutput("t4_after_grant", 32'(grant), 32'h10);
        checkOutput("t4_after_sel", 32'(portSel), 32'h80000);

        $display("[TB] destination errors");
        applyStimulus(5'b00010, 5'b00010, 5'b00010, dsts(0, 1, 0, 0, 0), 5'b11111);
        checkOutput("t5_self_err", 32'(destErr), 32'h02);
        checkOutput("t5_self_grant", 32'(grant), 32'h00);
        applyStimulus(5'b00100, 5'b00100, 5'b00100, dsts(0, 0, 7, 0, 0), 5'b11111);
        checkOutput("t5_range_err", 32'(destErr), 32'h04);
        checkOutput("t5_range_grant", 32'(grant), 32'h00);

        $display("[TB] reset in the middle of a packet");
        applyStimulus(5'b01000, 5'b01000, 5'b00000, dsts(0, 0, 0, 0, 0), 5'b11111);
        applyStimulus(5'b01000, 5'b00000, 5'b00000, dsts(0, 0, 0, 0, 0), 5'b11111);
        checkOutput("t6_pre_grant", 32'(grant), 32'h08);
        reset = 1'b1;
        req   = '0;
        hdr   = '0;
        tail  = '0;
        #1;
        checkOutput("t6_async_grant", 32'(grant), 32'h00);
        checkOutput("t6_async_valid", 32'(outValid), 32'h00);
        checkOutput("t6_async_sel", 32'(portSel), 32'h00000);
        modelReset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(5'b01000, 5'b00000, 5'b00000, dsts(0, 0, 0, 0, 0), 5'b11111);
        checkOutput("t6_body_grant", 32'(grant), 32'h00);
        applyStimulus(5'b01000, 5'b01000, 5'b01000, dsts(0, 0, 0, 0, 0), 5'b11111);
        checkOutput("t6_hdr_grant", 32'(grant), 32'h08);
        checkOutput("t6_hdr_sel", 32'(portSel), 32'h01000);

        $display("[TB] random packet traffic");
        for (int cyc = 0; cyc < 400; cyc++) begin
            gr = '0;
            gh = '0;
            gt = '0;
            gd = '0;
            for (int i = 0; i < N; i++) begin
                if (pktLeft[i] == 0 && $urandom_range(0, 2) == 0) begin
                    pktFirst[i] = 1'b1;
                    if ($urandom_range(0, 9) == 0) begin
                        pktBad[i]  = 1'b1;
                        pktDest[i] = ($urandom_range(0, 1) == 0) ? i : int'($urandom_range(N, 7));
                        pktLeft[i] = 1;
                    end else begin
                        pktBad[i]  = 1'b0;
                        pktDest[i] = (i + int'($urandom_range(1, N - 1))) % N;
                        pktLeft[i] = int'($urandom_range(1, 4));
                    end
                end
                if (pktLeft[i] > 0 && $urandom_range(0, 3) != 0) begin
                    gr[i]       = 1'b1;
                    gh[i]       = pktFirst[i];
                    gt[i]       = (pktLeft[i] == 1);
                    gd[i*W +: W] = W'(pktDest[i]);
                end else begin
                    gd[i*W +: W] = W'($urandom_range(0, 7));
                end
                grdy[i] = ($urandom_range(0, 3) != 0);
            end
            applyStimulus(gr, gh, gt, gd, grdy);
            for (int i = 0; i < N; i++) begin
                if (pktLeft[i] > 0 && gr[i]) begin
                    if (pktBad[i]) begin
                        pktLeft[i] = 0;
                    end else if (expGrant[i]) begin
                        pktLeft[i]  = pktLeft[i] - 1;
                        pktFirst[i] = 1'b0;
                    end
                end
            end
        end

        $display("[TB] random input noise");
        for (int cyc = 0; cyc < 150; cyc++) begin
            applyStimulus(N'($urandom), N'($urandom), N'($urandom),
                          (N*W)'($urandom), N'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
